// File: rtl/mrd_bfp_frame_norm.sv
// mrd_bfp_frame_norm
// Block-floating-point frame buffer placed between radix stages of the
// mixed-radix DFT datapath. One frame of FRAME_WORDS five-wide complex beats
// is collected while its common headroom (redundant sign bits, saturated to 3)
// is measured. The frame is then replayed with a constant margin_out/exp_out
// that the next radix-5 stage uses.
//
// Lane i of every 90-bit data bus sits at bits [18*i +: 18] (two's complement).
//
// Optional build feature: define MRD_BFP_FRAME_ERR_EN to add the sticky
// err_drop flag (beat offered while not ready) and the 8-bit frame_cnt
// counter of replayed frames.
//
// Timing: the last input beat is captured on edge E0. Drain issue reads run on
// E1..E(FRAME_WORDS), and the registered outputs follow one edge later. out_val
// is therefore high after E2..E(FRAME_WORDS+1). The block returns to FILL on the
// same edge that registers the final output beat.

module mrd_bfp_frame_norm #(
    parameter int FRAME_WORDS = 12,
    parameter int CW          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_val,
    output logic        in_rdy,
    input  logic [89:0] din_real,
    input  logic [89:0] din_imag,
    input  logic [3:0]  exp_in,
    output logic        out_val,
    output logic [89:0] dout_real,
    output logic [89:0] dout_imag,
    output logic [1:0]  margin_out,
    output logic [3:0]  exp_out,
    output logic        sof_out
`ifdef MRD_BFP_FRAME_ERR_EN
    ,
    output logic        err_drop,
    output logic [7:0]  frame_cnt
`endif
);

    localparam int            AW       = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_WORDS - 1);
    localparam logic [CW-1:0] FW_CNT   = CW'(FRAME_WORDS);

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Headroom of one sample: leading bits equal to the sign, minus one, capped at 3.
    function automatic logic [1:0] samp_headroom(input logic [17:0] s);
        logic [1:0] h;
        if (s[16] != s[17]) begin
            h = 2'd0;
        end else if (s[15] != s[17]) begin
            h = 2'd1;
        end else if (s[14] != s[17]) begin
            h = 2'd2;
        end else begin
            h = 2'd3;
        end
        return h;
    endfunction

    function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Headroom of a whole beat: minimum over all ten samples.
    function automatic logic [1:0] beat_headroom(input logic [89:0] re, input logic [89:0] im);
        logic [1:0] h;
        h = 2'd3;
        for (int i = 0; i < 5; i++) begin
            h = min2(h, samp_headroom(re[18*i +: 18]));
            h = min2(h, samp_headroom(im[18*i +: 18]));
        end
        return h;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0]    run_margin_q, run_margin_d;
    logic [3:0]    run_exp_q, run_exp_d;
    logic          in_rdy_q, in_rdy_d;
    logic [1:0]    margin_q, margin_d;
    logic [3:0]    exp_q, exp_d;

    logic          pipe_val_q;
    logic          pipe_sof_q;
    logic [AW-1:0] pipe_idx_q;
    logic          out_val_q;
    logic          sof_q;
    logic [89:0]   dout_re_q;
    logic [89:0]   dout_im_q;

    logic [89:0]   mem_re_q [FRAME_WORDS];
    logic [89:0]   mem_im_q [FRAME_WORDS];

    logic          accept_s;
    logic          issue_s;
    logic [1:0]    beat_h_s;
    logic [1:0]    merged_h_s;
    logic [3:0]    merged_exp_s;

    // Beat acceptance, drain issue and the running headroom/exponent merge.
    always_comb begin
        accept_s = in_val & in_rdy_q;
        issue_s  = (state_q == ST_DRAIN) && (rd_cnt_q < FW_CNT);
        beat_h_s = beat_headroom(din_real, din_imag);
        if (wr_cnt_q == {CW{1'b0}}) begin
            merged_h_s   = beat_h_s;
            merged_exp_s = exp_in;
        end else begin
            merged_h_s   = min2(run_margin_q, beat_h_s);
            merged_exp_s = run_exp_q;
        end
    end

    // Next-state logic for the FILL/DRAIN controller and frame statistics.
    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        run_margin_d = run_margin_q;
        run_exp_d    = run_exp_q;
        in_rdy_d     = in_rdy_q;
        margin_d     = margin_q;
        exp_d        = exp_q;
        case (state_q)
            ST_FILL: begin
                if (accept_s) begin
                    run_margin_d = merged_h_s;
                    run_exp_d    = merged_exp_s;
                    if (wr_cnt_q == LAST_IDX) begin
                        wr_cnt_d = {CW{1'b0}};
                        rd_cnt_d = {CW{1'b0}};
                        margin_d = merged_h_s;
                        exp_d    = merged_exp_s;
                        state_d  = ST_DRAIN;
                        in_rdy_d = 1'b0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    wr_cnt_d = wr_cnt_q;
                end
            end
            ST_DRAIN: begin
                // One extra step past the last issue lets the output register
                // catch the final beat before ready returns.
                if (rd_cnt_q == FW_CNT) begin
                    rd_cnt_d = {CW{1'b0}};
                    state_d  = ST_FILL;
                    in_rdy_d = 1'b1;
                end else begin
                    rd_cnt_d = rd_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d  = ST_FILL;
                wr_cnt_d = {CW{1'b0}};
                rd_cnt_d = {CW{1'b0}};
                in_rdy_d = 1'b1;
            end
        endcase
    end

    // Controller state, counters and frame statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FILL;
            wr_cnt_q     <= {CW{1'b0}};
            rd_cnt_q     <= {CW{1'b0}};
            run_margin_q <= 2'd3;
            run_exp_q    <= 4'd0;
            in_rdy_q     <= 1'b1;
            margin_q     <= 2'd0;
            exp_q        <= 4'd0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            run_margin_q <= run_margin_d;
            run_exp_q    <= run_exp_d;
            in_rdy_q     <= in_rdy_d;
            margin_q     <= margin_d;
            exp_q        <= exp_d;
        end
    end

    // Frame buffer: accepted beats are stored at the write index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FRAME_WORDS; i++) begin
                mem_re_q[i] <= 90'd0;
                mem_im_q[i] <= 90'd0;
            end
        end else begin
            if (accept_s) begin
                mem_re_q[wr_cnt_q[AW-1:0]] <= din_real;
                mem_im_q[wr_cnt_q[AW-1:0]] <= din_imag;
            end else begin
                mem_re_q[wr_cnt_q[AW-1:0]] <= mem_re_q[wr_cnt_q[AW-1:0]];
                mem_im_q[wr_cnt_q[AW-1:0]] <= mem_im_q[wr_cnt_q[AW-1:0]];
            end
        end
    end

    // Read-issue stage followed by the registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_val_q <= 1'b0;
            pipe_sof_q <= 1'b0;
            pipe_idx_q <= {AW{1'b0}};
            out_val_q  <= 1'b0;
            sof_q      <= 1'b0;
            dout_re_q  <= 90'd0;
            dout_im_q  <= 90'd0;
        end else begin
            pipe_val_q <= issue_s;
            pipe_sof_q <= issue_s && (rd_cnt_q == {CW{1'b0}});
            if (issue_s) begin
                pipe_idx_q <= rd_cnt_q[AW-1:0];
            end else begin
                pipe_idx_q <= pipe_idx_q;
            end
            out_val_q <= pipe_val_q;
            sof_q     <= pipe_sof_q;
            if (pipe_val_q) begin
                dout_re_q <= mem_re_q[pipe_idx_q];
                dout_im_q <= mem_im_q[pipe_idx_q];
            end else begin
                dout_re_q <= dout_re_q;
                dout_im_q <= dout_im_q;
            end
        end
    end

    assign in_rdy     = in_rdy_q;
    assign out_val    = out_val_q;
    assign sof_out    = sof_q;
    assign dout_real  = dout_re_q;
    assign dout_imag  = dout_im_q;
    assign margin_out = margin_q;
    assign exp_out    = exp_q;

`ifdef MRD_BFP_FRAME_ERR_EN
    logic       err_q;
    logic [7:0] frame_cnt_q;

    // Sticky drop flag and count of replayed frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q       <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            err_q <= err_q | (in_val & ~in_rdy_q);
            if (pipe_sof_q) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end else begin
                frame_cnt_q <= frame_cnt_q;
            end
        end
    end

    assign err_drop  = err_q;
    assign frame_cnt = frame_cnt_q;
`endif

endmodule
